reg_file_rename: RTL and testbench

Architectural register file with per-register rename tags. It sits between the dispatcher and the commit stage of the reorder buffer. On dispatch it records which ROB entry will produce each destination register, and it supplies operand values or producer tags to the dispatcher. On commit it retires values into the 32 architectural registers. On a mispredict flush it discards all speculative tags.

---
 rtl/reg_file_rename_pkg.sv | 24 ++
 rtl/reg_file_rename_read_port.sv | 51 +++++
 rtl/reg_file_rename.sv | 100 ++++++++++
 tb/tb_reg_file_rename.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_rename_pkg.sv
// Shared constants and types for the rename-aware register file.
// The ROB and dispatcher use the same widths and the "no producer" tag
// value, so they are defined once here rather than inside each block.
//
// Contents:
//   REG_NUM, DATA_W, ROB_SIZE, ROB_ID_W  - sizing constants
//   NON_DEP                              - tag meaning "value is architectural"
//   data_t / rob_id_t / reg_idx_t        - convenience typedefs
package reg_file_rename_pkg;

  localparam int REG_NUM   = 32;
  localparam int DATA_W    = 32;
  localparam int ROB_SIZE  = 16;
  localparam int ROB_ID_W  = 5;
  localparam int REG_IDX_W = $clog2(REG_NUM);

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ROB_ID_W-1:0]  rob_id_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One past the last real ROB entry, so it can never collide with a live tag.
  localparam rob_id_t NON_DEP = rob_id_t'(ROB_SIZE);

endpackage

// File: rtl/reg_file_rename_read_port.sv
// One combinational operand read port of the rename register file.
// Given the selected register's stored tag and value, it produces the
// producer tag and operand value the dispatcher needs, including a
// same-cycle bypass of a value that is being retired right now.
//
// Ports:
//   rs_i            - source register index
//   tag_i, val_i    - stored tag/value of register rs_i
//   commit_*_i      - commit bus from the ROB (used for the bypass)
//   q_o             - producer tag, NON_DEP when the value is available
//   v_o             - operand value, 0 while a producer is pending
module regfile_read_port
  import reg_file_rename_pkg::*;
(
  input  logic     [REG_IDX_W-1:0] rs_i,
  input  logic     [ROB_ID_W-1:0]  tag_i,
  input  logic     [DATA_W-1:0]    val_i,
  input  logic                     commit_en_i,
  input  logic     [REG_IDX_W-1:0] commit_rd_i,
  input  logic     [ROB_ID_W-1:0]  commit_rob_id_i,
  input  logic     [DATA_W-1:0]    commit_value_i,
  output logic     [ROB_ID_W-1:0]  q_o,
  output logic     [DATA_W-1:0]    v_o
);

  logic bypass_hit;

  // The bypass only fires when the retiring instruction is the one this
  // register is still waiting on; a younger rename must keep its tag.
  assign bypass_hit = commit_en_i && (commit_rd_i == rs_i) && (tag_i == commit_rob_id_i);

  // Priority: x0, then the in-flight commit, then the stored state.
  always_comb begin
    q_o = NON_DEP;
    v_o = '0;
    if (rs_i == '0) begin
      q_o = NON_DEP;
      v_o = '0;
    end else if (bypass_hit) begin
      q_o = NON_DEP;
      v_o = commit_value_i;
    end else if (tag_i == NON_DEP) begin
      q_o = NON_DEP;
      v_o = val_i;
    end else begin
      q_o = tag_i;
      v_o = '0;
    end
  end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Dispatch renames a destination to the ROB entry that will produce it;
// commit retires values into the architectural registers; a mispredict
// flush discards every speculative tag.
//
// Ports:
//   clk_i, rst_ni        - clock and synchronous active-low reset
//   rdy_i                - global ready; state holds while low
//   flush_i              - mispredict, clears all tags
//   rename_*_i           - destination rename from the dispatcher
//   rs1_i, rs2_i         - source indices; qj_o/vj_o, qk_o/vk_o results
//   commit_*_i           - register-writing retirement from the ROB
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rdy_i,
  input  logic                 flush_i,
  input  logic                 rename_en_i,
  input  logic [REG_IDX_W-1:0] rename_rd_i,
  input  logic [ROB_ID_W-1:0]  rename_rob_id_i,
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  output logic [ROB_ID_W-1:0]  qj_o,
  output logic [DATA_W-1:0]    vj_o,
  output logic [ROB_ID_W-1:0]  qk_o,
  output logic [DATA_W-1:0]    vk_o,
  input  logic                 commit_en_i,
  input  logic [REG_IDX_W-1:0] commit_rd_i,
  input  logic [ROB_ID_W-1:0]  commit_rob_id_i,
  input  logic [DATA_W-1:0]    commit_value_i
);

  data_t   val_q [REG_NUM];
  data_t   val_d [REG_NUM];
  rob_id_t tag_q [REG_NUM];
  rob_id_t tag_d [REG_NUM];

  // Next-state computation. Commit is applied first so that a rename of
  // the same register in the same cycle overwrites the cleared tag. A
  // flush wipes every tag and drops the rename, but the commit's value
  // still lands because that instruction is older than the branch.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (commit_en_i && (commit_rd_i != '0)) begin
      val_d[commit_rd_i] = commit_value_i;
      if (tag_q[commit_rd_i] == commit_rob_id_i) begin
        tag_d[commit_rd_i] = NON_DEP;
      end
    end
    if (flush_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = NON_DEP;
      end
    end else if (rename_en_i && (rename_rd_i != '0)) begin
      tag_d[rename_rd_i] = rename_rob_id_i;
    end
  end

  // State registers. Reset wins over rdy; with rdy low nothing moves.
  // Entry 0 is never written, so it stays at its reset value forever.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= NON_DEP;
      end
    end else if (rdy_i) begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  regfile_read_port u_read_rs1 (
    .rs_i            (rs1_i),
    .tag_i           (tag_q[rs1_i]),
    .val_i           (val_q[rs1_i]),
    .commit_en_i     (commit_en_i),
    .commit_rd_i     (commit_rd_i),
    .commit_rob_id_i (commit_rob_id_i),
    .commit_value_i  (commit_value_i),
    .q_o             (qj_o),
    .v_o             (vj_o)
  );

  regfile_read_port u_read_rs2 (
    .rs_i            (rs2_i),
    .tag_i           (tag_q[rs2_i]),
    .val_i           (val_q[rs2_i]),
    .commit_en_i     (commit_en_i),
    .commit_rd_i     (commit_rd_i),
    .commit_rob_id_i (commit_rob_id_i),
    .commit_value_i  (commit_value_i),
    .q_o             (qk_o),
    .v_o             (vk_o)
  );

endmodule

// File: tb/tb_reg_file_rename.sv
// Testbench for reg_file_rename. Stimulus is issued once per cycle; the
// expected operand reads for that cycle come from a behavioural model of
// the architectural state and are queued. A monitor on the falling edge
// pops each expectation and compares it against the DUT outputs.
module tb_reg_file_rename;

  localparam int NONDEP = 16;

  typedef struct {
    bit        rstN;
    bit        rdy;
    bit        flush;
    bit        renEn;
    bit [4:0]  renRd;
    bit [4:0]  renId;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit        comEn;
    bit [4:0]  comRd;
    bit [4:0]  comId;
    bit [31:0] comVal;
  } stim_t;

  typedef struct {
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit [4:0]  qj;
    bit [31:0] vj;
    bit [4:0]  qk;
    bit [31:0] vk;
  } expect_t;

  logic        clk;
  logic        rstN;
  logic        rdy;
  logic        flush;
  logic        renameEn;
  logic [4:0]  renameRd;
  logic [4:0]  renameRobId;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  qj;
  logic [31:0] vj;
  logic [4:0]  qk;
  logic [31:0] vk;
  logic        commitEn;
  logic [4:0]  commitRd;
  logic [4:0]  commitRobId;
  logic [31:0] commitValue;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  expect_t expQ[$];

  // Architectural model: committed value and pending producer per register.
  bit [31:0] mVal [32];
  int        mTag [32];

  reg_file_rename dut (
    .clk_i           (clk),
    .rst_ni          (rstN),
    .rdy_i           (rdy),
    .flush_i         (flush),
    .rename_en_i     (renameEn),
    .rename_rd_i     (renameRd),
    .rename_rob_id_i (renameRobId),
    .rs1_i           (rs1),
    .rs2_i           (rs2),
    .qj_o            (qj),
    .vj_o            (vj),
    .qk_o            (qk),
    .vk_o            (vk),
    .commit_en_i     (commitEn),
    .commit_rd_i     (commitRd),
    .commit_rob_id_i (commitRobId),
    .commit_value_i  (commitValue)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  function automatic stim_t idle();
    stim_t s;
    s.rstN = 1'b1; s.rdy = 1'b1; s.flush = 1'b0;
    s.renEn = 1'b0; s.renRd = '0; s.renId = '0;
    s.rs1 = '0; s.rs2 = '0;
    s.comEn = 1'b0; s.comRd = '0; s.comId = '0; s.comVal = '0;
    return s;
  endfunction

  // What the dispatcher should see for one source, given the stored state
  // and the commit currently on the bus.
  function automatic void modelRead(input bit [4:0] rs, input stim_t s,
                                    output bit [4:0] q, output bit [31:0] v);
    if (rs == 0) begin
      q = 5'(NONDEP); v = 0;
    end else if (s.comEn && s.comRd == rs && mTag[rs] == int'(s.comId)) begin
      q = 5'(NONDEP); v = s.comVal;
    end else if (mTag[rs] == NONDEP) begin
      q = 5'(NONDEP); v = mVal[rs];
    end else begin
      q = 5'(mTag[rs]); v = 0;
    end
  endfunction

  // Architectural effect of one clock edge.
  function automatic void modelStep(input stim_t s);
    if (!s.rstN) begin
      for (int i = 0; i < 32; i++) begin
        mVal[i] = 0;
        mTag[i] = NONDEP;
      end
    end else if (s.rdy) begin
      if (s.comEn && s.comRd != 0) begin
        mVal[s.comRd] = s.comVal;
        if (mTag[s.comRd] == int'(s.comId)) mTag[s.comRd] = NONDEP;
      end
      if (s.flush) begin
        for (int i = 0; i < 32; i++) mTag[i] = NONDEP;
      end else if (s.renEn && s.renRd != 0) begin
        mTag[s.renRd] = int'(s.renId);
      end
    end
  endfunction

  // Drive one cycle of inputs (called just after a rising edge), queue the
  // expected reads, then advance the model across the next rising edge.
  task automatic applyStimulus(input stim_t s, input bit doCheck);
    expect_t e;
    rstN = s.rstN; rdy = s.rdy; flush = s.flush;
    renameEn = s.renEn; renameRd = s.renRd; renameRobId = s.renId;
    rs1 = s.rs1; rs2 = s.rs2;
    commitEn = s.comEn; commitRd = s.comRd; commitRobId = s.comId; commitValue = s.comVal;
    if (doCheck) begin
      e.rs1 = s.rs1;
      e.rs2 = s.rs2;
      modelRead(s.rs1, s, e.qj, e.vj);
      modelRead(s.rs2, s, e.qk, e.vk);
      expQ.push_back(e);
    end
    @(posedge clk);
    modelStep(s);
    cycle++;
    #1;
  endtask

  task automatic checkOutput(input string name, input bit [31:0] got, input bit [31:0] want,
                             input bit [4:0] rs);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d rs=%0d got=%h want=%h", name, cycle, rs, got, want);
    end
  endtask

  // Monitor: the read outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      checkOutput("qj", 32'(qj), 32'(e.qj), e.rs1);
      checkOutput("vj", vj,      e.vj,      e.rs1);
      checkOutput("qk", 32'(qk), 32'(e.qk), e.rs2);
      checkOutput("vk", vk,      e.vk,      e.rs2);
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 32; i++) begin
      mVal[i] = 0;
      mTag[i] = NONDEP;
    end
    s = idle();
    s.rstN = 1'b0;
    rstN = 1'b0; rdy = 1'b1; flush = 1'b0; renameEn = 1'b0; renameRd = '0;
    renameRobId = '0; rs1 = '0; rs2 = '0; commitEn = 1'b0; commitRd = '0;
    commitRobId = '0; commitValue = '0;
    @(posedge clk);
    #1;

    // Reset: first edge clears state, second cycle checks rs1=5, rs2=0.
    applyStimulus(s, 1'b0);
    s.rs1 = 5'd5; s.rs2 = 5'd0;
    applyStimulus(s, 1'b1);

    // Every register comes out of reset with no producer and value 0.
    for (int i = 0; i < 32; i++) begin
      s = idle(); s.rs1 = 5'(i); s.rs2 = 5'(31 - i);
      applyStimulus(s, 1'b1);
    end

    // Rename x3 -> 7; same-cycle read does not see it, next cycle does.
    s = idle(); s.renEn = 1; s.renRd = 3; s.renId = 7; s.rs1 = 3;
    applyStimulus(s, 1'b1);
    s = idle(); s.rs1 = 3;
    applyStimulus(s, 1'b1);
    // Commit x3/7 with bypass, then visible through state.
    s = idle(); s.comEn = 1; s.comRd = 3; s.comId = 7; s.comVal = 32'hDEADBEEF; s.rs1 = 3;
    applyStimulus(s, 1'b1);
    s = idle(); s.rs1 = 3;
    applyStimulus(s, 1'b1);

    // Older commit must not clear a younger rename of x4.
    s = idle(); s.renEn = 1; s.renRd = 4; s.renId = 2;
    applyStimulus(s, 1'b1);
    s = idle(); s.renEn = 1; s.renRd = 4; s.renId = 5;
    applyStimulus(s, 1'b1);
    s = idle(); s.comEn = 1; s.comRd = 4; s.comId = 2; s.comVal = 32'h11; s.rs1 = 4;
    applyStimulus(s, 1'b1);
    s = idle(); s.rs1 = 4; s.rs2 = 3;
    applyStimulus(s, 1'b1);

    // Rename and commit of x6 in the same cycle: new tag wins, value written.
    s = idle(); s.renEn = 1; s.renRd = 6; s.renId = 9;
    s.comEn = 1; s.comRd = 6; s.comId = 9; s.comVal = 32'h22; s.rs1 = 6;
    applyStimulus(s, 1'b1);
    s = idle(); s.rs1 = 6;
    applyStimulus(s, 1'b1);
    s = idle(); s.comEn = 1; s.comRd = 6; s.comId = 9; s.comVal = 32'h22; s.rs2 = 6;
    applyStimulus(s, 1'b1);

    // Flush with a concurrent commit and a dropped rename.
    s = idle(); s.renEn = 1; s.renRd = 1; s.renId = 10; applyStimulus(s, 1'b1);
    s = idle(); s.renEn = 1; s.renRd = 2; s.renId = 11; applyStimulus(s, 1'b1);
    s = idle(); s.renEn = 1; s.renRd = 8; s.renId = 12; s.rs1 = 1; s.rs2 = 2;
    applyStimulus(s, 1'b1);
    s = idle(); s.flush = 1; s.comEn = 1; s.comRd = 1; s.comId = 10; s.comVal = 32'h33;
    s.renEn = 1; s.renRd = 9; s.renId = 13; s.rs1 = 8; s.rs2 = 1;
    applyStimulus(s, 1'b1);
    s = idle(); s.rs1 = 1; s.rs2 = 9; applyStimulus(s, 1'b1);
    s = idle(); s.rs1 = 2; s.rs2 = 8; applyStimulus(s, 1'b1);
    s = idle(); s.rs1 = 6; s.rs2 = 4; applyStimulus(s, 1'b1);

    // x0 writes are dropped; rdy low freezes state.
    s = idle(); s.renEn = 1; s.renRd = 0; s.renId = 3;
    s.comEn = 1; s.comRd = 0; s.comId = 3; s.comVal = 32'h44; s.rs1 = 0;
    applyStimulus(s, 1'b1);
    s = idle(); s.rdy = 0; s.renEn = 1; s.renRd = 5; s.renId = 4;
    s.comEn = 1; s.comRd = 7; s.comId = 1; s.comVal = 32'h55; s.rs1 = 0; s.rs2 = 5;
    applyStimulus(s, 1'b1);
    s = idle(); s.rs1 = 5; s.rs2 = 7; applyStimulus(s, 1'b1);

    // Randomized traffic; commits often target the live producer tag.
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rstN  = (n == 300) ? 1'b0 : 1'b1;
      s.rdy   = ($urandom_range(0, 9) != 0);
      s.flush = ($urandom_range(0, 24) == 0);
      s.renEn = $urandom_range(0, 1) == 1;
      s.renRd = 5'($urandom_range(0, 31));
      s.renId = 5'($urandom_range(0, 15));
      s.comEn = $urandom_range(0, 2) != 0;
      s.comRd = 5'($urandom_range(0, 31));
      if (mTag[s.comRd] != NONDEP && $urandom_range(0, 1) == 1)
        s.comId = 5'(mTag[s.comRd]);
      else
        s.comId = 5'($urandom_range(0, 15));
      s.comVal = $urandom;
      s.rs1 = ($urandom_range(0, 3) == 0) ? s.comRd : 5'($urandom_range(0, 31));
      s.rs2 = ($urandom_range(0, 3) == 0) ? s.renRd : 5'($urandom_range(0, 31));
      applyStimulus(s, 1'b1);
    end

    // Drain the scoreboard, with a bounded wait.
    s = idle();
    rstN = s.rstN; renameEn = 0; commitEn = 0; flush = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got=%0d want=0 pending entries", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
